// File: rtl/dot_product_mac.sv
// dot_product_mac: streams N signed Q8.8 (x, w) pairs, accumulates their
// full-precision products and returns the saturated Q8.8 dot product.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start                  begin a vector (sampled in IDLE only)
//   in_valid/in_ready, x, w                 input pair stream
//   out_valid/out_ready, weight_product     result stream
//   overflow               result was saturated (valid with out_valid)
//   busy                   high while accumulating or holding a result
module dot_product_mac #(
    parameter int N     = 4,
    parameter int ACC_W = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] weight_product,
    output logic        overflow,
    output logic        busy
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-32768);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;

    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] sum_nxt;
    logic signed [ACC_W-1:0] shifted;
    logic [15:0]             res_val;
    logic                    res_ovf;
    logic                    accept;

    assign accept = in_valid && in_ready;

    // Result is formed from the sum including the current product, so the
    // final pair's contribution lands in the same edge that enters DONE.
    always_comb begin
        prod    = $signed(x) * $signed(w);
        sum_nxt = acc + ACC_W'(prod);
        shifted = sum_nxt >>> 8;
        res_ovf = 1'b1;
        if (shifted > S_MAX) begin
            res_val = 16'h7FFF;
        end else if (shifted < S_MIN) begin
            res_val = 16'h8000;
        end else begin
            res_val = shifted[15:0];
            res_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            acc            <= '0;
            cnt            <= '0;
            weight_product <= 16'h0000;
            overflow       <= 1'b0;
            in_ready       <= 1'b0;
            out_valid      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= ACCUM;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= sum_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            weight_product <= res_val;
                            overflow       <= res_ovf;
                            state          <= DONE;
                            in_ready       <= 1'b0;
                            out_valid      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_mac.sv
// tb_dot_product_mac: directed bench for dot_product_mac (N=4 and N=1
// instances) checked against a longint behavioural model every cycle.
module tb_dot_product_mac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st[2];
    logic        iv[2];
    logic        irdy[2];
    logic [15:0] xs[2];
    logic [15:0] ws[2];
    logic        ov[2];
    logic        ordy[2];
    logic [15:0] wp[2];
    logic        of[2];
    logic        bz[2];

    int tests = 0;
    int fails = 0;
    int nn[2] = '{4, 1};

    always #5 clk = ~clk;

    dot_product_mac #(.N(4), .ACC_W(40)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]),
        .in_valid(iv[0]), .in_ready(irdy[0]),
        .x(xs[0]), .w(ws[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .weight_product(wp[0]), .overflow(of[0]), .busy(bz[0])
    );

    dot_product_mac #(.N(1), .ACC_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]),
        .in_valid(iv[1]), .in_ready(irdy[1]),
        .x(xs[1]), .w(ws[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .weight_product(wp[1]), .overflow(of[1]), .busy(bz[1])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Spec-level result rule: floor(sum / 256), then clamp to int16.
    function automatic logic [16:0] q88(input longint sum);
        longint s;
        s = sum >>> 8;
        if (s > 32767) return {1'b1, 16'h7FFF};
        if (s < -32768) return {1'b1, 16'h8000};
        return {1'b0, s[15:0]};
    endfunction

    function automatic longint pr(input logic [15:0] a, input logic [15:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    typedef enum {M_IDLE, M_ACC, M_DONE} mph_t;
    mph_t        mph[2];
    int          mcnt[2];
    longint      msum[2];
    logic [15:0] mres[2];
    logic        movf[2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mph[k]  <= M_IDLE;
                mcnt[k] <= 0;
                msum[k] <= 0;
                mres[k] <= 16'h0000;
                movf[k] <= 1'b0;
            end else begin
                case (mph[k])
                    M_IDLE: if (st[k]) begin
                        mph[k]  <= M_ACC;
                        mcnt[k] <= 0;
                        msum[k] <= 0;
                    end
                    M_ACC: if (iv[k]) begin
                        msum[k] <= msum[k] + pr(xs[k], ws[k]);
                        mcnt[k] <= mcnt[k] + 1;
                        if (mcnt[k] == nn[k] - 1) begin
                            {movf[k], mres[k]} <= q88(msum[k] + pr(xs[k], ws[k]));
                            mph[k] <= M_DONE;
                        end
                    end
                    default: if (ordy[k]) mph[k] <= M_IDLE;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("in_ready[%0d]", k), 32'(irdy[k]),
                    32'(mph[k] == M_ACC));
                chk($sformatf("out_valid[%0d]", k), 32'(ov[k]),
                    32'(mph[k] == M_DONE));
                chk($sformatf("busy[%0d]", k), 32'(bz[k]),
                    32'(mph[k] != M_IDLE));
                if (mph[k] == M_DONE) begin
                    chk($sformatf("wp[%0d]", k), 32'(wp[k]), 32'(mres[k]));
                    chk($sformatf("ovf[%0d]", k), 32'(of[k]), 32'(movf[k]));
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_in_ready"}, 32'(irdy[k]), 32'(0));
            chk({tag, "_out_valid"}, 32'(ov[k]), 32'(0));
            chk({tag, "_busy"}, 32'(bz[k]), 32'(0));
            chk({tag, "_wp"}, 32'(wp[k]), 32'(0));
            chk({tag, "_ovf"}, 32'(of[k]), 32'(0));
        end
    endtask

    // Entry and exit: #1 after a rising edge with the DUT in IDLE.
    task automatic run_vec(input int k, input logic [15:0] x0,
                           input logic [15:0] xstep, input logic [15:0] wv,
                           input bit rnd, input bit hold,
                           input logic [15:0] ewp, input logic eovf,
                           input string nm);
        int i;
        int budget;
        i = 0;
        budget = 0;
        ordy[k] = hold ? 1'b0 : 1'b1;
        st[k] = 1'b1;
        @(posedge clk);
        #1 st[k] = 1'b0;
        while (i < nn[k] && budget < 200) begin
            iv[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            xs[k] = x0 + 16'(i) * xstep;
            ws[k] = wv;
            @(posedge clk);
            #1;
            if (iv[k]) i++;
            budget++;
        end
        iv[k] = 1'b0;
        if (i < nn[k]) chk({nm, "_timeout"}, 32'(i), 32'(nn[k]));
        chk({nm, "_latency"}, 32'(ov[k]), 32'(1));
        chk({nm, "_wp"}, 32'(wp[k]), 32'(ewp));
        chk({nm, "_ovf"}, 32'(of[k]), 32'(eovf));
        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                st[k] = (c == 3);
                @(posedge clk);
                #1;
                chk({nm, "_hold_valid"}, 32'(ov[k]), 32'(1));
                chk({nm, "_hold_wp"}, 32'(wp[k]), 32'(ewp));
            end
            st[k] = 1'b0;
            ordy[k] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({nm, "_release"}, 32'(ov[k]), 32'(0));
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0;
            iv[k] = 1'b0;
            xs[k] = 16'h0000;
            ws[k] = 16'h0000;
            ordy[k] = 1'b1;
        end

        chk("model_sublsb", 32'(q88(512)), 32'h00002);
        chk("model_negfloor", 32'(q88(-128)), 32'h0FFFF);
        chk("model_neg4", 32'(q88(-512)), 32'h0FFFE);
        chk("model_satpos", 32'(q88(64'sd2621440000)), 32'h17FFF);
        chk("model_satneg", 32'(q88(-64'sd2621440000)), 32'h18000);

        #12;
        chk_reset_vals("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_vec(0, 16'h0100, 16'h0000, 16'h0200, 0, 0, 16'h0800, 0, "basic");
        run_vec(0, 16'h0001, 16'h0000, 16'h0080, 0, 0, 16'h0002, 0, "sublsb");
        run_vec(0, 16'hFFFF, 16'h0000, 16'h0080, 0, 0, 16'hFFFE, 0, "negA");
        run_vec(0, 16'hF600, 16'h0000, 16'h0100, 0, 0, 16'hD800, 0, "negC");
        run_vec(0, 16'h6400, 16'h0000, 16'h6400, 0, 0, 16'h7FFF, 1, "satpos");
        run_vec(0, 16'h9C00, 16'h0000, 16'h6400, 0, 0, 16'h8000, 1, "satneg");
        run_vec(0, 16'h0100, 16'h0080, 16'h0300, 1, 1, 16'h1500, 0, "hshake");

        run_vec(1, 16'hFFFF, 16'h0000, 16'h0080, 0, 0, 16'hFFFF, 0, "n1negB");
        run_vec(1, 16'h6400, 16'h0000, 16'h6400, 1, 0, 16'h7FFF, 1, "n1sat");

        // Abort a vector after two pairs with a sub-cycle reset pulse.
        st[0] = 1'b1;
        @(posedge clk);
        #1 st[0] = 1'b0;
        xs[0] = 16'h0300;
        ws[0] = 16'h0200;
        iv[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 iv[0] = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(0, 16'h0100, 16'h0000, 16'h0200, 0, 0, 16'h0800, 0, "postrst");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dot_product_mac.md
# dot_product_mac

Sequential multiply-accumulate stage for a single neuron. Accepts N (input, weight) pairs in signed Q8.8 over a valid/ready stream and accumulates their products at full precision. Produces the saturated Q8.8 dot product on a valid/ready output. The output feeds the `weight_product` input of the downstream activation stage, which adds the bias and applies the nonlinearity.

## Interface
- `N`, default 4: number of pairs per dot product; legal range 1..256.
- `ACC_W`, default 40: accumulator width in bits; must be at least 32 + ceil(log2 N).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous assert, active-low; release is synchronised externally.
- `start` in 1: begin a new dot product; sampled only in IDLE.
- `in_valid` in 1: `x`/`w` pair valid.
- `in_ready` out 1: stage accepts a pair this cycle.
- `x` in 16: signed Q8.8 input activation.
- `w` in 16: signed Q8.8 weight.
- `out_valid` out 1: `weight_product` valid.
- `out_ready` in 1: consumer accepts the result.
- `weight_product` out 16: signed Q8.8 saturated dot product, registered.
- `overflow` out 1: result was saturated; valid with `out_valid`.
- `busy` out 1: high in ACCUM or DONE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- **IDLE**
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 causes: accumulator cleared to 0, pair counter cleared to 0, next state ACCUM.
- **ACCUM**
  - `in_ready`=1.
  - Pair accepted when `in_valid` && `in_ready`. On acceptance: acc += sext(x*w), counter += 1.
  - `x*w` is a 32-bit signed Q16.16 product, sign-extended to `ACC_W`. No rounding or saturation inside the accumulator.
  - On acceptance of pair number N (counter == N-1), the following happen in the same edge: the final product is added, the result is computed from the updated sum, the result is registered into `weight_product`/`overflow`, and the next state is DONE.
  - `in_valid`=0 leaves acc and counter unchanged; there is no timeout.
- **Result computation**
  - s = sum >>> 8: arithmetic shift, truncation toward negative infinity.
  - If s > 32767: output 0x7FFF, `overflow`=1.
  - If s < -32768: output 0x8000, `overflow`=1.
  - Otherwise: output s[15:0], `overflow`=0.
- **DONE**
  - `out_valid`=1.
  - `weight_product` and `overflow` are held stable until the handshake completes.
  - `out_valid` && `out_ready` causes next state IDLE.
- `start` is ignored in ACCUM and DONE; no restart mid-vector.
- `start` may be asserted again in the cycle after the DONE handshake (first cycle back in IDLE).

## Timing
- **Reset** (asynchronous, `rst_n`=0), all take effect immediately:
  - state=IDLE, acc=0, counter=0.
  - `weight_product`=0x0000, `overflow`=0, `out_valid`=0, `in_ready`=0, `busy`=0.
- **Reset mid-operation**
  - Partial sum is discarded.
  - No `out_valid` is produced for the aborted vector.
- **Latency**
  - `in_ready` rises 1 cycle after `start` is sampled.
  - `out_valid` rises 1 cycle after the N-th pair is accepted.
  - Minimum start-to-result time is N+1 cycles (with `in_valid` held high).
- **Throughput**: one pair per cycle; a new vector can start 1 cycle after the output handshake.
- **Backpressure**: `out_ready`=0 holds DONE indefinitely; `in_ready` stays 0 in DONE.
- **N=1**: ACCUM lasts until one pair is accepted, then the FSM goes to DONE.
- **Combinational paths**: outputs depend only on state; there is no combinational path from any input to `in_ready` or `out_valid`.

## Test plan
- **Basic sum**
  - Stimulus: N=4, `x`=0x0100 (1.0), `w`=0x0200 (2.0) for all 4 pairs, streamed back-to-back.
  - Response: `out_valid` on cycle start+5; `weight_product`=0x0800 (8.0), `overflow`=0.
- **Sub-LSB precision kept**
  - Stimulus: `x`=0x0001, `w`=0x0080 ×4.
  - Response: 0x0002, because the full-precision sum is 512 and 512>>>8 = 2. Per-product truncation would give 0.
- **Negative floor**
  - Stimulus A: `x`=0xFFFF, `w`=0x0080 ×4. Response: 0xFFFE.
  - Stimulus B: same pair with N=1. Response: 0xFFFF (−128>>>8 = −1).
  - Stimulus C: `x`=0xF600 (−10.0), `w`=0x0100 ×4. Response: 0xD800 (−40.0).
- **Saturation**
  - Stimulus: `x`=`w`=0x6400 (100.0) ×4; sum is 40000.
  - Response: 0x7FFF, `overflow`=1.
  - Same pairs with `x`=0x9C00 (−100.0): response 0x8000, `overflow`=1.
- **Handshakes**
  - Toggle `in_valid` pseudo-randomly.
  - Hold `out_ready`=0 for 10 cycles after `out_valid` rises.
  - Response: the result equals the ideal sum; the output is stable for all 10 cycles; `in_ready`=0 throughout; `start` pulsed during DONE is ignored.
- **Reset mid-vector**
  - Stimulus: after 2 of 4 pairs, pulse `rst_n` low for less than 1 cycle (asynchronous), then run the basic-sum vector.
  - Response: all outputs are at their reset values immediately after `rst_n` falls; the next result is 0x0800, with no residue from the aborted vector.
